// File: rtl/debug_host_pkg.sv
// Shared debug-host definitions: FSM state encoding, command codes
// and the expected response length of each command.
package debug_host_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND,
        ST_WAIT_TX,
        ST_RECV,
        ST_FLUSH
    } state_t;

    localparam logic [7:0] CMD_REGISTERS  = 8'h01;
    localparam logic [7:0] CMD_IF_ID      = 8'h02;
    localparam logic [7:0] CMD_ID_EX      = 8'h03;
    localparam logic [7:0] CMD_EX_MEM     = 8'h04;
    localparam logic [7:0] CMD_MEM_WB     = 8'h05;
    localparam logic [7:0] CMD_MEMORY     = 8'h06;
    localparam logic [7:0] CMD_CTRL_FIRST = 8'h07;
    localparam logic [7:0] CMD_CTRL_LAST  = 8'h0D;

    localparam logic [7:0] LEN_REGISTERS = 8'd128;
    localparam logic [7:0] LEN_IF_ID     = 8'd4;
    localparam logic [7:0] LEN_ID_EX     = 8'd17;
    localparam logic [7:0] LEN_EX_MEM    = 8'd10;
    localparam logic [7:0] LEN_MEM_WB    = 8'd9;
    localparam logic [7:0] LEN_MEMORY    = 8'd4;
    localparam logic [7:0] LEN_CTRL      = 8'd0;

    // Control commands (07..0D) and unknown codes carry no response.
    function automatic logic [7:0] resp_len(input logic [7:0] cmd);
        case (cmd)
            CMD_REGISTERS: resp_len = LEN_REGISTERS;
            CMD_IF_ID:     resp_len = LEN_IF_ID;
            CMD_ID_EX:     resp_len = LEN_ID_EX;
            CMD_EX_MEM:    resp_len = LEN_EX_MEM;
            CMD_MEM_WB:    resp_len = LEN_MEM_WB;
            CMD_MEMORY:    resp_len = LEN_MEMORY;
            default:       resp_len = LEN_CTRL;
        endcase
    endfunction

endpackage

// File: rtl/debug_host_if.sv
// Command handshake and packed response word channel of debug_host.
// master: issues commands and consumes words; slave: the debug host.
interface debug_host_if #(
    parameter int WORD_BYTES = 4
);
    logic                    cmd_valid;
    logic [7:0]              cmd;
    logic [7:0]              cmd_len;
    logic                    cmd_ready;
    logic                    word_valid;
    logic [8*WORD_BYTES-1:0] word;
    logic                    word_last;

    modport master (
        output cmd_valid, cmd, cmd_len,
        input  cmd_ready, word_valid, word, word_last
    );

    modport slave (
        input  cmd_valid, cmd, cmd_len,
        output cmd_ready, word_valid, word, word_last
    );
endinterface

// File: rtl/debug_host_byte_packer.sv
// byte_packer: assembles little-endian bytes into words, zero-padding
// a short final word. Ports: i_clear drops the partial word,
// i_valid/i_byte/i_last feed bytes, o_word_* is a registered pulse.
module byte_packer #(
    parameter int WORD_BYTES = 4
) (
    input  logic                    i_clk,
    input  logic                    i_reset,
    input  logic                    i_clear,
    input  logic                    i_valid,
    input  logic [7:0]              i_byte,
    input  logic                    i_last,
    output logic                    o_word_valid,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_word_last
);
    localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam logic [IW-1:0] IDX_LAST = IW'(WORD_BYTES - 1);

    logic [8*WORD_BYTES-1:0] r_acc;
    logic [IW-1:0]           r_idx;
    logic [8*WORD_BYTES-1:0] w_merged;
    logic                    w_full;

    always_comb begin
        w_merged = r_acc;
        w_merged[8*r_idx +: 8] = i_byte;
    end

    assign w_full = (r_idx == IDX_LAST);

    // Accumulator restarts from zero after every emitted word, which
    // is what leaves the unfilled upper bytes of a short word at zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_acc        <= '0;
            r_idx        <= '0;
            o_word       <= '0;
            o_word_valid <= 1'b0;
            o_word_last  <= 1'b0;
        end else begin
            o_word_valid <= 1'b0;
            o_word_last  <= 1'b0;
            if (i_clear) begin
                r_acc <= '0;
                r_idx <= '0;
            end else if (i_valid) begin
                if (w_full || i_last) begin
                    o_word       <= w_merged;
                    o_word_valid <= 1'b1;
                    o_word_last  <= i_last;
                    r_acc        <= '0;
                    r_idx        <= '0;
                end else begin
                    r_acc <= w_merged;
                    r_idx <= r_idx + IW'(1);
                end
            end
        end
    end

endmodule

// File: rtl/debug_host.sv
// debug_host: sends a command byte over the UART, then collects the
// response into packed words with an inter-byte timeout.
// Ports: io_bus (command/word channel), o_tx_*/i_tx_done (UART TX),
// i_rx_* (UART RX), o_busy, o_timeout and o_drop status pulses.
module debug_host
    import debug_host_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535,
    parameter int WORD_BYTES     = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    debug_host_if.slave io_bus,
    output logic       o_tx_start,
    output logic [7:0] o_tx_data,
    input  logic       i_tx_done,
    input  logic       i_rx_valid,
    input  logic [7:0] i_rx_data,
    output logic       o_busy,
    output logic       o_timeout,
    output logic       o_drop
);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    state_t                  r_state;
    logic [7:0]              r_cmd;
    logic [7:0]              r_len;
    logic [7:0]              r_count;
    logic [TW-1:0]           r_tmo;
    logic                    r_tx_start;
    logic                    r_busy;
    logic                    r_ready;
    logic                    r_timeout;
    logic                    r_drop;

    logic                    w_accept;
    logic                    w_rx_take;
    logic                    w_last_byte;
    logic                    w_expire;
    logic                    w_word_valid;
    logic [8*WORD_BYTES-1:0] w_word;
    logic                    w_word_last;

    assign w_accept    = io_bus.cmd_valid && (r_state == ST_IDLE);
    assign w_rx_take   = i_rx_valid && (r_state == ST_RECV);
    assign w_last_byte = (r_count == r_len - 8'd1);
    // A coincident byte always beats the timeout.
    assign w_expire    = (r_state == ST_RECV) && !i_rx_valid
                         && (r_tmo == TMO_LAST);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_cmd      <= '0;
            r_len      <= '0;
            r_count    <= '0;
            r_tmo      <= '0;
            r_tx_start <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_timeout  <= 1'b0;
            r_drop     <= 1'b0;
        end else begin
            r_tx_start <= 1'b0;
            r_timeout  <= 1'b0;
            r_drop     <= i_rx_valid && (r_state != ST_RECV);
            unique case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_cmd      <= io_bus.cmd;
                        r_len      <= io_bus.cmd_len;
                        r_state    <= ST_SEND;
                        r_tx_start <= 1'b1;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                    end
                end
                ST_SEND: r_state <= ST_WAIT_TX;
                ST_WAIT_TX: begin
                    if (i_tx_done) begin
                        r_count <= '0;
                        r_tmo   <= '0;
                        if (r_len != 8'd0) begin
                            r_state <= ST_RECV;
                        end else begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_ready <= 1'b1;
                        end
                    end
                end
                ST_RECV: begin
                    if (i_rx_valid) begin
                        r_tmo <= '0;
                        if (w_last_byte) r_state <= ST_FLUSH;
                        else r_count <= r_count + 8'd1;
                    end else if (w_expire) begin
                        r_timeout <= 1'b1;
                        r_state   <= ST_IDLE;
                        r_busy    <= 1'b0;
                        r_ready   <= 1'b1;
                    end else begin
                        r_tmo <= r_tmo + TW'(1);
                    end
                end
                ST_FLUSH: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    byte_packer #(
        .WORD_BYTES (WORD_BYTES)
    ) u_packer (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_clear      (w_accept || w_expire),
        .i_valid      (w_rx_take),
        .i_byte       (i_rx_data),
        .i_last       (w_last_byte),
        .o_word_valid (w_word_valid),
        .o_word       (w_word),
        .o_word_last  (w_word_last)
    );

    assign io_bus.cmd_ready  = r_ready;
    assign io_bus.word_valid = w_word_valid;
    assign io_bus.word       = w_word;
    assign io_bus.word_last  = w_word_last;
    assign o_tx_start        = r_tx_start;
    assign o_tx_data         = r_cmd;
    assign o_busy            = r_busy;
    assign o_timeout         = r_timeout;
    assign o_drop            = r_drop;

endmodule

// File: tb/tb_debug_host.sv
// Directed testbench for debug_host (TIMEOUT_CYCLES=16, WORD_BYTES=4).
// A negedge monitor records words and pulses; each test checks them.
module tb_debug_host;

    logic       clk;
    logic       reset;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_done;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       busy;
    logic       timeout;
    logic       drop;

    int n_tests;
    int n_fail;

    logic [31:0] wq[$];
    logic        lq[$];
    int          n_tx;
    int          n_drop;
    int          n_tmo;

    debug_host_if #(.WORD_BYTES(4)) bus ();

    debug_host #(
        .TIMEOUT_CYCLES (16),
        .WORD_BYTES     (4)
    ) dut (
        .i_clk      (clk),
        .i_reset    (reset),
        .io_bus     (bus),
        .o_tx_start (tx_start),
        .o_tx_data  (tx_data),
        .i_tx_done  (tx_done),
        .i_rx_valid (rx_valid),
        .i_rx_data  (rx_data),
        .o_busy     (busy),
        .o_timeout  (timeout),
        .o_drop     (drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.word_valid) begin
            wq.push_back(bus.word);
            lq.push_back(bus.word_last);
        end
        if (tx_start) n_tx++;
        if (drop) n_drop++;
        if (timeout) n_tmo++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [7:0] c, input logic [7:0] l);
        int k;
        k = 0;
        while (!bus.cmd_ready && k < 200) begin
            tick();
            k++;
        end
        if (!bus.cmd_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_ready: cmd_ready=0 after %0d cycles, need 1", k);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd       = c;
        bus.cmd_len   = l;
        tick();
        bus.cmd_valid = 1'b0;
    endtask

    task automatic tx_ack();
        tick();
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        repeat (gap) tick();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();
        n_tests++;
        if (bus.cmd_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_ready: got %b need 1", bus.cmd_ready);
        end
        n_tests++;
        if ({busy, tx_start, timeout, drop} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_flags: got %b need 0000",
                     {busy, tx_start, timeout, drop});
        end
        n_tests++;
        if ({tx_data, bus.word, bus.word_valid, bus.word_last} !== 42'd0) begin
            n_fail++;
            $display("FAIL reset_data: tx=%h word=%h need 0", tx_data, bus.word);
        end
    endtask

    task automatic test_word_response();
        int wb, tb0, db;
        wb  = wq.size();
        tb0 = n_tx;
        db  = n_drop;
        issue(8'h06, 8'd4);
        n_tests++;
        if ({tx_start, tx_data, busy, bus.cmd_ready} !== {1'b1, 8'h06, 2'b10}) begin
            n_fail++;
            $display("FAIL word_send: start=%b data=%h busy=%b rdy=%b need 1 06 1 0",
                     tx_start, tx_data, busy, bus.cmd_ready);
        end
        tick();
        n_tests++;
        if ({tx_start, tx_data} !== {1'b0, 8'h06}) begin
            n_fail++;
            $display("FAIL word_hold: start=%b data=%h need 0 06", tx_start, tx_data);
        end
        tx_ack();
        send_byte(8'h78, 1);
        send_byte(8'h56, 0);
        send_byte(8'h34, 2);
        send_byte(8'h12, 0);
        send_byte(8'hEE, 3);
        n_tests++;
        if (wq.size() - wb !== 1) begin
            n_fail++;
            $display("FAIL word_count: got %0d need 1", wq.size() - wb);
        end else begin
            n_tests++;
            if ({wq[wb], lq[wb]} !== {32'h12345678, 1'b1}) begin
                n_fail++;
                $display("FAIL word_value: got %h last=%b need 12345678 1",
                         wq[wb], lq[wb]);
            end
        end
        n_tests++;
        if (n_tx - tb0 !== 1) begin
            n_fail++;
            $display("FAIL word_txpulses: got %0d need 1", n_tx - tb0);
        end
        n_tests++;
        if (n_drop - db !== 1) begin
            n_fail++;
            $display("FAIL flush_drop: got %0d need 1", n_drop - db);
        end
    endtask

    task automatic test_partial();
        int wb;
        logic [31:0] exp_w [3];
        logic        exp_l [3];
        exp_w[0] = 32'h04030201;
        exp_w[1] = 32'h08070605;
        exp_w[2] = 32'h00000009;
        exp_l[0] = 1'b0;
        exp_l[1] = 1'b0;
        exp_l[2] = 1'b1;
        wb = wq.size();
        issue(8'h05, 8'd9);
        tx_ack();
        for (int i = 1; i <= 9; i++) send_byte(8'(i), i % 2);
        repeat (3) tick();
        n_tests++;
        if (wq.size() - wb !== 3) begin
            n_fail++;
            $display("FAIL partial_count: got %0d need 3", wq.size() - wb);
        end else begin
            for (int i = 0; i < 3; i++) begin
                n_tests++;
                if ({wq[wb+i], lq[wb+i]} !== {exp_w[i], exp_l[i]}) begin
                    n_fail++;
                    $display("FAIL partial_w%0d: got %h/%b need %h/%b",
                             i, wq[wb+i], lq[wb+i], exp_w[i], exp_l[i]);
                end
            end
        end
    endtask

    task automatic test_dump();
        int wb, db, bad;
        logic [31:0] e;
        wb  = wq.size();
        db  = n_drop;
        bad = 0;
        issue(8'h01, 8'd128);
        tx_ack();
        for (int i = 0; i < 128; i++) send_byte(8'(i), 0);
        repeat (3) tick();
        n_tests++;
        if (wq.size() - wb !== 32) begin
            n_fail++;
            $display("FAIL dump_count: got %0d need 32", wq.size() - wb);
        end else begin
            for (int k = 0; k < 32; k++) begin
                e = {8'(4*k+3), 8'(4*k+2), 8'(4*k+1), 8'(4*k)};
                if (wq[wb+k] !== e || lq[wb+k] !== (k == 31)) bad++;
            end
            n_tests++;
            if (bad != 0) begin
                n_fail++;
                $display("FAIL dump_words: %0d bad words, need 0", bad);
            end
            n_tests++;
            if ({wq[wb+31], lq[wb+31]} !== {32'h7F7E7D7C, 1'b1}) begin
                n_fail++;
                $display("FAIL dump_last: got %h/%b need 7f7e7d7c/1",
                         wq[wb+31], lq[wb+31]);
            end
        end
        n_tests++;
        if (n_drop - db !== 0) begin
            n_fail++;
            $display("FAIL dump_drop: got %0d need 0", n_drop - db);
        end
    endtask

    task automatic test_timeout();
        int wb, cyc;
        wb = wq.size();
        issue(8'h06, 8'd4);
        tx_ack();
        send_byte(8'hA1, 1);
        send_byte(8'hA2, 0);
        cyc = 0;
        while (!timeout && cyc < 40) begin
            tick();
            cyc++;
        end
        n_tests++;
        if (cyc !== 16) begin
            n_fail++;
            $display("FAIL tmo_cycles: got %0d need 16", cyc);
        end
        n_tests++;
        if ({bus.cmd_ready, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_idle: rdy=%b busy=%b need 1 0", bus.cmd_ready, busy);
        end
        tick();
        n_tests++;
        if ({bus.cmd_ready, timeout} !== 2'b10) begin
            n_fail++;
            $display("FAIL tmo_after: rdy=%b tmo=%b need 1 0", bus.cmd_ready, timeout);
        end
        n_tests++;
        if (wq.size() - wb !== 0) begin
            n_fail++;
            $display("FAIL tmo_words: got %0d need 0", wq.size() - wb);
        end
    endtask

    task automatic test_timeout_priority();
        int wb, t0;
        wb = wq.size();
        t0 = n_tmo;
        issue(8'h02, 8'd4);
        tx_ack();
        send_byte(8'h11, 15);
        send_byte(8'h22, 0);
        send_byte(8'h33, 15);
        send_byte(8'h44, 3);
        n_tests++;
        if (n_tmo - t0 !== 0) begin
            n_fail++;
            $display("FAIL prio_tmo: got %0d timeouts need 0", n_tmo - t0);
        end
        n_tests++;
        if (wq.size() - wb !== 1) begin
            n_fail++;
            $display("FAIL prio_count: got %0d need 1", wq.size() - wb);
        end else begin
            n_tests++;
            if ({wq[wb], lq[wb]} !== {32'h44332211, 1'b1}) begin
                n_fail++;
                $display("FAIL prio_word: got %h/%b need 44332211/1", wq[wb], lq[wb]);
            end
        end
    endtask

    task automatic test_no_response();
        int wb, tb0;
        wb  = wq.size();
        tb0 = n_tx;
        issue(8'h0A, 8'd0);
        bus.cmd_valid = 1'b1;
        bus.cmd       = 8'h01;
        bus.cmd_len   = 8'd4;
        repeat (4) tick();
        n_tests++;
        if ({busy, bus.cmd_ready, tx_data} !== {2'b10, 8'h0A}) begin
            n_fail++;
            $display("FAIL nr_wait: busy=%b rdy=%b data=%h need 1 0 0a",
                     busy, bus.cmd_ready, tx_data);
        end
        bus.cmd_valid = 1'b0;
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        n_tests++;
        if ({busy, bus.cmd_ready} !== 2'b01) begin
            n_fail++;
            $display("FAIL nr_idle: busy=%b rdy=%b need 0 1", busy, bus.cmd_ready);
        end
        tx_done = 1'b1;
        tick();
        tx_done = 1'b0;
        send_byte(8'h5A, 0);
        n_tests++;
        if ({drop, busy} !== 2'b10) begin
            n_fail++;
            $display("FAIL nr_drop: drop=%b busy=%b need 1 0", drop, busy);
        end
        tick();
        n_tests++;
        if (drop !== 1'b0) begin
            n_fail++;
            $display("FAIL nr_drop_pulse: got %b need 0", drop);
        end
        n_tests++;
        if (wq.size() - wb !== 0 || n_tx - tb0 !== 1) begin
            n_fail++;
            $display("FAIL nr_words: words=%0d tx=%0d need 0 1",
                     wq.size() - wb, n_tx - tb0);
        end
    endtask

    task automatic test_reset_mid();
        int wb;
        issue(8'h06, 8'd4);
        tx_ack();
        send_byte(8'h01, 0);
        send_byte(8'h02, 0);
        reset = 1'b1;
        tick();
        n_tests++;
        if ({busy, tx_start, timeout, drop, bus.word_valid, bus.word_last,
             bus.cmd_ready} !== 7'b0000001) begin
            n_fail++;
            $display("FAIL rmid_flags: got %b need 0000001",
                     {busy, tx_start, timeout, drop, bus.word_valid,
                      bus.word_last, bus.cmd_ready});
        end
        n_tests++;
        if ({tx_data, bus.word} !== 40'd0) begin
            n_fail++;
            $display("FAIL rmid_data: tx=%h word=%h need 0", tx_data, bus.word);
        end
        reset = 1'b0;
        tick();
        wb = wq.size();
        issue(8'h06, 8'd4);
        n_tests++;
        if ({tx_start, tx_data} !== {1'b1, 8'h06}) begin
            n_fail++;
            $display("FAIL rmid_send: start=%b data=%h need 1 06", tx_start, tx_data);
        end
        tx_ack();
        send_byte(8'hAA, 0);
        send_byte(8'hBB, 0);
        send_byte(8'hCC, 0);
        send_byte(8'hDD, 3);
        n_tests++;
        if (wq.size() - wb !== 1) begin
            n_fail++;
            $display("FAIL rmid_count: got %0d need 1", wq.size() - wb);
        end else begin
            n_tests++;
            if ({wq[wb], lq[wb]} !== {32'hDDCCBBAA, 1'b1}) begin
                n_fail++;
                $display("FAIL rmid_word: got %h/%b need ddccbbaa/1", wq[wb], lq[wb]);
            end
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        reset         = 1'b1;
        tx_done       = 1'b0;
        rx_valid      = 1'b0;
        rx_data       = 8'h00;
        bus.cmd_valid = 1'b0;
        bus.cmd       = 8'h00;
        bus.cmd_len   = 8'h00;
        test_reset();
        test_word_response();
        test_partial();
        test_dump();
        test_timeout();
        test_timeout_priority();
        test_no_response();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
